enoc_injection_queue: RTL and testbench

ENOC_INJECTION_QUEUE -- requirements
Module: enoc_injection_queue

---
 rtl/enoc_injection_queue.sv | 67 ++++++
 tb/tb_enoc_injection_queue.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/enoc_injection_queue.sv
// enoc_injection_queue: FWFT injection buffer from a traffic node into local network port 0,
// with saturating delivered-word and stall-cycle statistics.
module enoc_injection_queue #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [DATA_WIDTH-1:0]      i_data,
   input  logic                       i_data_val,
   output logic                       o_en,
   output logic [DATA_WIDTH-1:0]      o_data,
   output logic                       o_data_val,
   input  logic                       i_en,
   input  logic                       i_flush,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic [CNT_WIDTH-1:0]       o_sent_cnt,
   output logic [CNT_WIDTH-1:0]       o_stall_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [CNT_WIDTH-1:0]  sent_q, sent_d, stall_q, stall_d;
   logic                  push, pop;

   assign o_en        = (count_q < CW'(DEPTH)) & ~i_flush;
   assign o_data_val  = count_q != '0;
   assign o_data      = mem_q[rd_ptr_q];
   assign o_count     = count_q;
   assign o_sent_cnt  = sent_q;
   assign o_stall_cnt = stall_q;
   assign push        = i_data_val & o_en;
   assign pop         = o_data_val & i_en;

   // Flush blocks push via o_en, so aligning rd to the unchanged wr empties the queue.
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = i_flush ? wr_ptr_q : (pop ? rd_ptr_q + AW'(1) : rd_ptr_q);
      count_d  = i_flush ? '0 : count_q + CW'(push) - CW'(pop);
      sent_d   = (pop && sent_q != '1) ? sent_q + CNT_WIDTH'(1) : sent_q;
      stall_d  = (o_data_val && !i_en && stall_q != '1) ? stall_q + CNT_WIDTH'(1) : stall_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         sent_q   <= '0;
         stall_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         sent_q   <= sent_d;
         stall_q  <= stall_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= i_data;
   end
endmodule

// File: tb/tb_enoc_injection_queue.sv
// tb_enoc_injection_queue: directed checks of ordering, full/empty, flush, reset and counter saturation.
module tb_enoc_injection_queue;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] i_data = '0;
   logic       i_data_val = 1'b0;
   logic       o_en;
   logic [7:0] o_data;
   logic       o_data_val;
   logic       i_en = 1'b0;
   logic       i_flush = 1'b0;
   logic [2:0] o_count;
   logic [3:0] o_sent_cnt, o_stall_cnt;
   int         n_cmp = 0;
   int         n_err = 0;

   enoc_injection_queue #(.DATA_WIDTH(8), .DEPTH(4), .CNT_WIDTH(4)) dut (
      .clk(clk), .reset(reset), .i_data(i_data), .i_data_val(i_data_val), .o_en(o_en),
      .o_data(o_data), .o_data_val(o_data_val), .i_en(i_en), .i_flush(i_flush),
      .o_count(o_count), .o_sent_cnt(o_sent_cnt), .o_stall_cnt(o_stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset;
      @(negedge clk);
      reset = 1'b1;
      #2;
      reset = 1'b0;
   endtask

   task automatic idle;
      i_data_val = 1'b0;
      i_en = 1'b0;
      i_flush = 1'b0;
   endtask

   initial begin
      #3;
      check("rst_count", o_count, 0);
      check("rst_val", o_data_val, 0);
      check("rst_en", o_en, 1);
      check("rst_sent", o_sent_cnt, 0);
      check("rst_stall", o_stall_cnt, 0);
      tick;
      reset = 1'b0;

      // single word, fall-through latency and stall counting
      i_data = 8'hA1; i_data_val = 1'b1;
      tick;
      i_data_val = 1'b0;
      check("lat_data", o_data, 8'hA1);
      check("lat_val", o_data_val, 1);
      check("lat_count", o_count, 1);
      check("lat_stall0", o_stall_cnt, 0);
      repeat (3) tick;
      check("stall3", o_stall_cnt, 3);

      // fill to full, reject 5th word, drain in order
      pulse_reset;
      for (int k = 1; k <= 4; k++) begin
         i_data = 8'(k); i_data_val = 1'b1;
         tick;
      end
      check("full_count", o_count, 4);
      check("full_en", o_en, 0);
      i_data = 8'h05;
      tick;
      check("full_hold", o_count, 4);
      i_data_val = 1'b0; i_en = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         check($sformatf("drain%0d", k), o_data, k);
         tick;
      end
      check("drain_sent", o_sent_cnt, 4);
      check("drain_count", o_count, 0);
      check("drain_val", o_data_val, 0);
      idle;

      // steady push+pop at occupancy 2 across pointer wrap
      pulse_reset;
      for (int k = 0; k < 2; k++) begin
         i_data = 8'h10 + 8'(k); i_data_val = 1'b1;
         tick;
      end
      i_en = 1'b1;
      for (int k = 0; k < 10; k++) begin
         i_data = 8'h12 + 8'(k);
         check($sformatf("stream_d%0d", k), o_data, 8'h10 + k);
         tick;
         check($sformatf("stream_c%0d", k), o_count, 2);
      end
      check("stream_sent", o_sent_cnt, 10);

      // flush with a simultaneous pop
      i_data = 8'h30; i_en = 1'b0;
      tick;
      check("pre_flush_count", o_count, 3);
      i_data = 8'h40; i_flush = 1'b1; i_en = 1'b1;
      #1;
      check("flush_en", o_en, 0);
      tick;
      i_flush = 1'b0; i_en = 1'b0; i_data_val = 1'b0;
      check("flush_count", o_count, 0);
      check("flush_val", o_data_val, 0);
      check("flush_sent", o_sent_cnt, 11);
      i_data = 8'h41; i_data_val = 1'b1;
      tick;
      i_data_val = 1'b0;
      check("post_flush_data", o_data, 8'h41);
      check("post_flush_count", o_count, 1);

      // asynchronous reset mid-cycle with 3 queued words
      pulse_reset;
      for (int k = 0; k < 3; k++) begin
         i_data = 8'h50 + 8'(k); i_data_val = 1'b1;
         tick;
      end
      i_data_val = 1'b0;
      check("pre_arst_count", o_count, 3);
      #2;
      reset = 1'b1;
      #1;
      check("arst_count", o_count, 0);
      check("arst_val", o_data_val, 0);
      check("arst_sent", o_sent_cnt, 0);
      check("arst_stall", o_stall_cnt, 0);
      #1;
      reset = 1'b0;
      i_en = 1'b1;
      repeat (2) tick;
      check("arst_no_deliver", o_data_val, 0);
      check("arst_sent_after", o_sent_cnt, 0);
      idle;

      // stall counter saturation
      pulse_reset;
      i_data = 8'h77; i_data_val = 1'b1;
      tick;
      i_data_val = 1'b0;
      repeat (14) tick;
      check("stall14", o_stall_cnt, 14);
      repeat (6) tick;
      check("stall_sat", o_stall_cnt, 15);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
